alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Upstream command stage for the 2-bit ALU. Accepts operand/select commands over a
//   valid/ready handshake and drives alu_a/alu_b/alu_sel stable into the combinational ALU.
//   Waits a fixed settle time, then captures alu_y and returns it on a valid/ready
//   response channel. Handles one command in flight and counts completed operations.
// PARAMETERS
//   OPW        2   operand width (alu_a, alu_b)
//   SELW       2   select width (alu_sel)
//   RESW       4   result width (alu_y, rsp_y)
//   SETTLE_CYC 1   cycles operands are held before alu_y is captured; legal range 1..15
//   CNTW       8   width of op_count
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   cmd_valid  in   1     command present
//   cmd_ready  out  1     sequencer can accept a command
//   cmd_a      in   OPW   operand A
//   cmd_b      in   OPW   operand B
//   cmd_sel    in   SELW  ALU select
//   alu_a      out  OPW   registered operand A to ALU
//   alu_b      out  OPW   registered operand B to ALU
//   alu_sel    out  SELW  registered select to ALU
//   alu_y      in   RESW  combinational ALU result
//   rsp_valid  out  1     response present
//   rsp_ready  in   1     consumer accepts response
//   rsp_y      out  RESW  captured result
//   rsp_sel    out  SELW  select that produced rsp_y
//   busy       out  1     high in any state other than IDLE
//   op_count   out  CNTW  completed responses, wraps at 2^CNTW
// BEHAVIOUR
//   Reset (async assert, deassert synchronised by the caller): state=IDLE, all outputs 0.
//   - cmd_ready=1 after reset; settle counter=0.
//   FSM states: IDLE, EXEC, RESP.
//   - IDLE: cmd_ready=1. On cmd_valid: register cmd_a/b/sel into alu_a/b/sel,
//     load settle counter with SETTLE_CYC-1, go to EXEC.
//   - EXEC: cmd_ready=0, alu_* held. When counter==0: capture rsp_y<=alu_y and
//     rsp_sel<=alu_sel, go to RESP. Otherwise decrement the counter.
//   - RESP: rsp_valid=1; rsp_y/rsp_sel stable until accepted. On rsp_ready: op_count+1
//     (wraps 2^CNTW-1 -> 0), rsp_valid<=0, go to IDLE.
//   Latency: accept edge -> rsp_valid high = SETTLE_CYC+1 cycles (2 at default).
//   Minimum issue interval: SETTLE_CYC+2 cycles.
//   alu_a/b/sel change only on an IDLE accept. They hold the last command otherwise.
//   Simultaneous rsp_ready and cmd_valid in RESP: response retires, command not accepted
//   (cmd_ready=0). The command is accepted in the following IDLE cycle if still valid.
//   cmd_* ignored outside IDLE. rsp_ready ignored outside RESP.
//   Reset mid-EXEC/RESP: operation aborted, no response, op_count cleared to 0.
// CONFIGURATION
//   ALU_SEQ_PARITY_EN defined: extra output rsp_par (1 bit) = ^rsp_y, captured with
//   rsp_y, reset 0.
//   ALU_SEQ_PARITY_EN undefined: port rsp_par absent. All other behaviour is identical.
// STRUCTURE
//   alu_seq_pkg: state encoding localparams (IDLE=2'd0, EXEC=2'd1, RESP=2'd2),
//   default widths, SETTLE_CYC legal bounds.
//   One sub-module: alu_seq_settle_cnt (loadable 4-bit down-counter with zero flag).
//   The ALU itself is instantiated by the parent, not inside this block.
// TESTING
//   Bench ALU stub: alu_y = {alu_a, alu_b}.
//   1 reset, cmd a=2'b10 b=2'b01 sel=2'b11, rsp_ready=1 -> alu_*=10/01/11 one cycle
//     after accept; rsp_valid 2 cycles after accept; rsp_y=4'b1001, rsp_sel=2'b11;
//     op_count=1.
//   2 hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_y stable; cmd_ready=0.
//     A cmd_valid driven meanwhile is not accepted until IDLE.
//   3 SETTLE_CYC=3 -> rsp_valid exactly 4 cycles after accept. Change alu_y stub output
//     before capture -> last-cycle value captured.
//   4 assert rst_n=0 during EXEC -> all outputs 0 immediately, no rsp_valid after
//     release, op_count=0.
//   5 256 back-to-back ops with rsp_ready=1 -> op_count wraps 255->0.
//     Issue interval = SETTLE_CYC+2.
//   6 ALU_SEQ_PARITY_EN defined, result 4'b1011 -> rsp_par=1; result 4'b0011 -> rsp_par=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU operation sequencer:
//   - default widths
//   - the settle-time bounds
//   - the FSM state encoding
//   - a helper that turns a settle time into a counter load value
//   No ports (package).
//   Configuration macro used by the sequencer: ALU_SEQ_PARITY_EN.

package alu_seq_pkg;

  localparam int OPW_DEF     = 2;
  localparam int SELW_DEF    = 2;
  localparam int RESW_DEF    = 4;
  localparam int SETTLE_DEF  = 1;
  localparam int CNTW_DEF    = 8;

  localparam int SETTLE_MIN  = 1;
  localparam int SETTLE_MAX  = 15;
  localparam int SETTLE_CNTW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // The counter counts down to zero inclusive, so it is loaded with settle-1.
  // Out-of-range settle values are clamped into the legal window.
  function automatic logic [SETTLE_CNTW-1:0] settle_load(input int settle);
    int clamped;
    clamped = (settle < SETTLE_MIN) ? SETTLE_MIN :
              (settle > SETTLE_MAX) ? SETTLE_MAX : settle;
    return SETTLE_CNTW'(clamped - 1);
  endfunction

endpackage

// File: rtl/alu_seq_settle_cnt.sv
// alu_seq_settle_cnt
//   Loadable down-counter with a zero flag. It times how long the ALU operands
//   are held before the result is captured.
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   W-bit value to load
//   dec      in   decrement; the counter saturates at zero
//   zero     out  count == 0

module alu_seq_settle_cnt
  import alu_seq_pkg::*;
#(
  parameter int W = SETTLE_CNTW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Upstream command stage for the combinational ALU.
//   - Accepts one command (operands + select) over a valid/ready handshake.
//   - Holds the operands steady on alu_a/alu_b/alu_sel for SETTLE_CYC cycles.
//   - Captures alu_y and returns it on a valid/ready response channel.
//   - Counts completed responses.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_a, cmd_b, cmd_sel       command payload
//   alu_a, alu_b, alu_sel       registered operands to the ALU
//   alu_y                       combinational ALU result
//   rsp_valid/rsp_ready         response handshake
//   rsp_y, rsp_sel              captured result and the select that produced it
//   busy                        high whenever not IDLE
//   op_count                    completed responses, wrapping
//   rsp_par                     even parity of rsp_y (only with ALU_SEQ_PARITY_EN)
// Configuration
//   ALU_SEQ_PARITY_EN   adds the rsp_par output.

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPW        = OPW_DEF,
  parameter int SELW       = SELW_DEF,
  parameter int RESW       = RESW_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  input  logic [SELW-1:0] cmd_sel,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [SELW-1:0] alu_sel,
  input  logic [RESW-1:0] alu_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RESW-1:0] rsp_y,
  output logic [SELW-1:0] rsp_sel,
  output logic            busy,
  output logic [CNTW-1:0] op_count
`ifdef ALU_SEQ_PARITY_EN
  ,
  output logic            rsp_par
`endif
);

  localparam logic [SETTLE_CNTW-1:0] SETTLE_LOAD = settle_load(SETTLE_CYC);

  seq_state_e state_q, state_d;
  logic       accept, capture, retire;
  logic       cnt_load, cnt_dec, cnt_zero;

  alu_seq_settle_cnt #(.W(SETTLE_CNTW)) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A retiring response always returns to IDLE first, so a command presented
  // in the same cycle waits one cycle before it is accepted.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    retire   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      alu_a   <= cmd_a;
      alu_b   <= cmd_b;
      alu_sel <= cmd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y   <= '0;
      rsp_sel <= '0;
    end else if (capture) begin
      rsp_y   <= alu_y;
      rsp_sel <= alu_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (retire) begin
      op_count <= op_count + 1'b1;
    end
  end

`ifdef ALU_SEQ_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_par <= 1'b0;
    end else if (capture) begin
      rsp_par <= ^alu_y;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Two sequencer instances are driven with directed vectors:
//   - instance 0 uses the default settle time of 1
//   - instance 1 uses a settle time of 3
//   A behavioural model tracks each in-flight operation by its accept time and age.
//   Every cycle, a compare process checks both instances against the model.
//   Directed checks with hand-computed literals pin the model's behaviour.
//   Each ALU stub returns {alu_a, alu_b} unless an override value is forced.
//   Honors ALU_SEQ_PARITY_EN for the rsp_par output.

module tb_alu_op_sequencer;

  localparam int SET0 = 1;
  localparam int SET1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_a     [2];
  logic [1:0] cmd_b     [2];
  logic [1:0] cmd_sel   [2];
  logic [1:0] alu_a     [2];
  logic [1:0] alu_b     [2];
  logic [1:0] alu_sel   [2];
  logic [3:0] alu_y     [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [3:0] rsp_y     [2];
  logic [1:0] rsp_sel   [2];
  logic       busy      [2];
  logic [7:0] op_count  [2];
  logic       ovr_en    [2];
  logic [3:0] ovr_val   [2];
`ifdef ALU_SEQ_PARITY_EN
  logic       rsp_par   [2];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign alu_y[0] = ovr_en[0] ? ovr_val[0] : {alu_a[0], alu_b[0]};
  assign alu_y[1] = ovr_en[1] ? ovr_val[1] : {alu_a[1], alu_b[1]};

  alu_op_sequencer #(.SETTLE_CYC(SET0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_sel(cmd_sel[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_y(alu_y[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_y(rsp_y[0]), .rsp_sel(rsp_sel[0]), .busy(busy[0]), .op_count(op_count[0])
`ifdef ALU_SEQ_PARITY_EN
    , .rsp_par(rsp_par[0])
`endif
  );

  alu_op_sequencer #(.SETTLE_CYC(SET1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_sel(cmd_sel[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_y(alu_y[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_y(rsp_y[1]), .rsp_sel(rsp_sel[1]), .busy(busy[1]), .op_count(op_count[1])
`ifdef ALU_SEQ_PARITY_EN
    , .rsp_par(rsp_par[1])
`endif
  );

  // Model state: one operation in flight per instance, identified by the edge index
  // at which it was accepted. Its age (edges since acceptance) decides whether it is
  // still settling or waiting for its response to be taken.
  int         m_cyc;
  logic       m_busy     [2];
  int         m_acc_edge [2];
  logic [1:0] m_a        [2];
  logic [1:0] m_b        [2];
  logic [1:0] m_sel      [2];
  logic [3:0] m_y        [2];
  logic [1:0] m_rsel     [2];
  int         m_count    [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? SET0 : SET1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_acc_edge[i] = 0; m_a[i] = '0; m_b[i] = '0; m_sel[i] = '0;
        m_y[i] = '0; m_rsel[i] = '0; m_count[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int age;
        age = m_cyc - m_acc_edge[i];
        if (m_busy[i] && age == settle_of(i) - 1) begin
          m_y[i]    = ovr_en[i] ? ovr_val[i] : {m_a[i], m_b[i]};
          m_rsel[i] = m_sel[i];
        end
        if (m_busy[i] && age >= settle_of(i)) begin
          if (rsp_ready[i]) begin
            m_busy[i]  = 1'b0;
            m_count[i] = (m_count[i] + 1) % 256;
          end
        end else if (!m_busy[i] && cmd_valid[i]) begin
          m_busy[i]     = 1'b1;
          m_acc_edge[i] = m_cyc + 1;
          m_a[i]        = cmd_a[i];
          m_b[i]        = cmd_b[i];
          m_sel[i]      = cmd_sel[i];
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic exp_valid;
        exp_valid = m_busy[i] && ((m_cyc - m_acc_edge[i]) >= settle_of(i));
        checkOutput($sformatf("model_ctrl%0d", i),
                    {29'd0, cmd_ready[i], busy[i], rsp_valid[i]},
                    {29'd0, !m_busy[i], m_busy[i], exp_valid});
        checkOutput($sformatf("model_alu%0d", i),
                    {26'd0, alu_a[i], alu_b[i], alu_sel[i]},
                    {26'd0, m_a[i], m_b[i], m_sel[i]});
        checkOutput($sformatf("model_count%0d", i), {24'd0, op_count[i]}, m_count[i]);
        if (exp_valid) begin
          checkOutput($sformatf("model_rsp%0d", i),
                      {26'd0, rsp_y[i], rsp_sel[i]}, {26'd0, m_y[i], m_rsel[i]});
`ifdef ALU_SEQ_PARITY_EN
          checkOutput($sformatf("model_par%0d", i), {31'd0, rsp_par[i]}, {31'd0, ^m_y[i]});
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] s, input logic rr);
    cmd_valid[i] = v;
    cmd_a[i]     = a;
    cmd_b[i]     = b;
    cmd_sel[i]   = s;
    rsp_ready[i] = rr;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts, last_acc, min_iv, max_iv, cyc;
    bit wrapped;
    logic [7:0] prev_cnt;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(i, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
      ovr_en[i]  = 1'b0;
      ovr_val[i] = 4'h0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready0", {31'd0, cmd_ready[0]}, 32'd1);
    checkOutput("rst_outs0", {15'd0, rsp_valid[0], busy[0], op_count[0], rsp_y[0], alu_a[0], alu_b[0]}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: a=10 b=01 sel=11 with default settle
    applyStimulus(0, 1'b1, 2'b10, 2'b01, 2'b11, 1'b1);
    tick();
    cmd_valid[0] = 1'b0;
    checkOutput("t1_alu", {26'd0, alu_a[0], alu_b[0], alu_sel[0]}, {26'd0, 6'b10_01_11});
    checkOutput("t1_valid_early", {31'd0, rsp_valid[0]}, 32'd0);
    tick();
    checkOutput("t1_valid", {31'd0, rsp_valid[0]}, 32'd1);
    checkOutput("t1_rsp", {26'd0, rsp_y[0], rsp_sel[0]}, {26'd0, 6'b1001_11});
    tick();
    checkOutput("t1_count", {24'd0, op_count[0]}, 32'd1);
    checkOutput("t1_done", {31'd0, rsp_valid[0]}, 32'd0);

    // T2: back-pressure in RESP, then a command that overlaps the retiring response
    applyStimulus(0, 1'b1, 2'b01, 2'b10, 2'b01, 1'b0);
    tick();
    cmd_valid[0] = 1'b0;
    tick();
    applyStimulus(0, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t2_hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
      checkOutput("t2_hold_rsp", {26'd0, rsp_y[0], rsp_sel[0]}, {26'd0, 6'b0110_01});
      checkOutput("t2_hold_ready", {31'd0, cmd_ready[0]}, 32'd0);
      checkOutput("t2_hold_alu", {30'd0, alu_a[0]}, 32'd1);
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    checkOutput("t2_retire", {30'd0, rsp_valid[0], cmd_ready[0]}, 32'b01);
    checkOutput("t2_not_taken", {30'd0, alu_a[0]}, 32'd1);
    checkOutput("t2_count", {24'd0, op_count[0]}, 32'd2);
    tick();
    cmd_valid[0] = 1'b0;
    checkOutput("t2_taken", {26'd0, alu_a[0], alu_b[0], alu_sel[0]}, {26'd0, 6'b11_11_00});
    repeat (2) tick();
    checkOutput("t2_count2", {24'd0, op_count[0]}, 32'd3);

    // T3: settle 3, stub output changes before capture
    applyStimulus(1, 1'b1, 2'b01, 2'b11, 2'b10, 1'b1);
    tick();
    cmd_valid[1] = 1'b0;
    checkOutput("t3_v1", {31'd0, rsp_valid[1]}, 32'd0);
    ovr_en[1]  = 1'b1;
    ovr_val[1] = 4'b0110;
    tick();
    checkOutput("t3_v2", {31'd0, rsp_valid[1]}, 32'd0);
    tick();
    checkOutput("t3_v3", {31'd0, rsp_valid[1]}, 32'd0);
    ovr_val[1] = 4'b1110;
    tick();
    checkOutput("t3_v4", {31'd0, rsp_valid[1]}, 32'd1);
    checkOutput("t3_rsp", {26'd0, rsp_y[1], rsp_sel[1]}, {26'd0, 6'b1110_10});
    ovr_en[1] = 1'b0;
    tick();
    checkOutput("t3_count", {24'd0, op_count[1]}, 32'd1);

    // T4: reset during EXEC
    applyStimulus(1, 1'b1, 2'b10, 2'b10, 2'b01, 1'b1);
    tick();
    cmd_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_outs1", {12'd0, rsp_valid[1], busy[1], op_count[1], rsp_y[1], alu_a[1], alu_b[1], alu_sel[1]}, 32'd0);
    checkOutput("t4_count0", {24'd0, op_count[0]}, 32'd0);
    checkOutput("t4_ready1", {31'd0, cmd_ready[1]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t4_no_rsp", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);
    end

    // T5: 256 back-to-back operations wrap the counter
    applyStimulus(0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
    accepts = 1; last_acc = 0; min_iv = 1000; max_iv = 0; cyc = 0;
    wrapped = 1'b0;
    prev_cnt = op_count[0];
    while (!wrapped && cyc < 1000) begin
      tick();
      cyc++;
      if (prev_cnt == 8'd255 && op_count[0] == 8'd0) wrapped = 1'b1;
      prev_cnt = op_count[0];
      if (!wrapped && cmd_ready[0]) begin
        if (cyc - last_acc < min_iv) min_iv = cyc - last_acc;
        if (cyc - last_acc > max_iv) max_iv = cyc - last_acc;
        last_acc = cyc;
        accepts++;
        cmd_a[0] = 2'(accepts);
        cmd_b[0] = 2'(accepts >> 2);
        cmd_sel[0] = 2'(accepts >> 4);
      end
    end
    cmd_valid[0] = 1'b0;
    checkOutput("t5_wrap", {31'd0, wrapped}, 32'd1);
    checkOutput("t5_accepts", accepts, 32'd256);
    checkOutput("t5_min_interval", min_iv, 32'd3);
    checkOutput("t5_max_interval", max_iv, 32'd3);
    tick();

`ifdef ALU_SEQ_PARITY_EN
    // T6: parity of captured results
    applyStimulus(0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b1);
    tick();
    cmd_valid[0] = 1'b0;
    tick();
    checkOutput("t6_par_1011", {27'd0, rsp_y[0], rsp_par[0]}, {27'd0, 5'b1011_1});
    tick();
    applyStimulus(0, 1'b1, 2'b00, 2'b11, 2'b00, 1'b1);
    tick();
    cmd_valid[0] = 1'b0;
    tick();
    checkOutput("t6_par_0011", {27'd0, rsp_y[0], rsp_par[0]}, {27'd0, 5'b0011_0});
    tick();
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
